// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
//   Registered immediate extender for RV32I/RV64I. It decodes the immediate,
//   classifies its format and flags unsupported opcodes. Results leave
//   through a valid/ready stage that holds two entries: the output register
//   plus one skid entry. in_ready depends only on the skid state, so there is
//   no combinational path from out_ready to in_ready.
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   in_valid/in_ready input handshake; in_ready = !skid_full
//   instr, in_tag     raw instruction word and opaque sideband tag
//   out_valid/out_ready output handshake
//   out_imm           extended immediate (XLEN bits)
//   out_fmt           0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 CSR
//   out_illegal       unsupported opcode or shamt out of range
//   out_tag           tag that travelled with the instruction
module imm_extend_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;
  localparam logic [2:0] FMT_CSR   = 3'd7;

  // ---------------- decode ----------------
  logic [6:0]      opcode;
  logic            is_shift;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_ill;

  assign opcode   = instr[6:0];
  assign is_shift = (instr[14:12] == 3'b001) || (instr[14:12] == 3'b101);

  // Every supported opcode ends in 2'b11, so compressed encodings fall into
  // the default arm and come out illegal.
  always_comb begin
    dec_imm = '0;
    dec_fmt = FMT_NONE;
    dec_ill = 1'b0;
    case (opcode)
      7'b0110111, 7'b0010111: begin
        dec_fmt = FMT_U;
        dec_imm = XLEN'($signed({instr[31:12], 12'b0}));
      end
      7'b1101111: begin
        dec_fmt = FMT_J;
        dec_imm = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                 instr[30:21], 1'b0}));
      end
      7'b1100111, 7'b0000011: begin
        dec_fmt = FMT_I;
        dec_imm = XLEN'($signed(instr[31:20]));
      end
      7'b1100011: begin
        dec_fmt = FMT_B;
        dec_imm = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                 instr[11:8], 1'b0}));
      end
      7'b0100011: begin
        dec_fmt = FMT_S;
        dec_imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      end
      7'b0010011: begin
        if (is_shift) begin
          dec_fmt = FMT_SHAMT;
          if (XLEN == 64) begin
            dec_imm = XLEN'(instr[25:20]);
          end else begin
            // shamt[5] set has no meaning on a 32-bit datapath
            dec_imm = XLEN'(instr[24:20]);
            dec_ill = instr[25];
          end
        end else begin
          dec_fmt = FMT_I;
          dec_imm = XLEN'($signed(instr[31:20]));
        end
      end
      7'b0011011: begin
        if (XLEN == 64) begin
          if (is_shift) begin
            dec_fmt = FMT_SHAMT;
            dec_imm = XLEN'(instr[24:20]);
          end else begin
            dec_fmt = FMT_I;
            dec_imm = XLEN'($signed(instr[31:20]));
          end
        end else begin
          dec_ill = 1'b1;
        end
      end
      7'b1110011: begin
        dec_fmt = FMT_CSR;
        dec_imm = XLEN'(instr[31:20]);
      end
      7'b0110011, 7'b0111011: begin
        dec_fmt = FMT_NONE;
      end
      default: begin
        dec_ill = 1'b1;
      end
    endcase
  end

  // ---------------- output register + skid entry ----------------
  logic             out_valid_q,   out_valid_d;
  logic [XLEN-1:0]  out_imm_q,     out_imm_d;
  logic [2:0]       out_fmt_q,     out_fmt_d;
  logic             out_illegal_q, out_illegal_d;
  logic [TAG_W-1:0] out_tag_q,     out_tag_d;

  logic             skid_full_q,   skid_full_d;
  logic [XLEN-1:0]  skid_imm_q,    skid_imm_d;
  logic [2:0]       skid_fmt_q,    skid_fmt_d;
  logic             skid_ill_q,    skid_ill_d;
  logic [TAG_W-1:0] skid_tag_q,    skid_tag_d;

  logic in_xfer;
  logic out_load;

  assign in_ready = !skid_full_q;
  assign in_xfer  = in_valid && in_ready;
  assign out_load = !out_valid_q || out_ready;

  always_comb begin
    out_valid_d   = out_valid_q;
    out_imm_d     = out_imm_q;
    out_fmt_d     = out_fmt_q;
    out_illegal_d = out_illegal_q;
    out_tag_d     = out_tag_q;
    skid_full_d   = skid_full_q;
    skid_imm_d    = skid_imm_q;
    skid_fmt_d    = skid_fmt_q;
    skid_ill_d    = skid_ill_q;
    skid_tag_d    = skid_tag_q;
    if (out_load) begin
      // A full skid holds the older result, so it always goes first; in_ready
      // is low in that case, so no input can be lost here.
      if (skid_full_q) begin
        out_valid_d   = 1'b1;
        out_imm_d     = skid_imm_q;
        out_fmt_d     = skid_fmt_q;
        out_illegal_d = skid_ill_q;
        out_tag_d     = skid_tag_q;
        skid_full_d   = 1'b0;
      end else if (in_xfer) begin
        out_valid_d   = 1'b1;
        out_imm_d     = dec_imm;
        out_fmt_d     = dec_fmt;
        out_illegal_d = dec_ill;
        out_tag_d     = in_tag;
      end else begin
        out_valid_d   = 1'b0;
      end
    end else if (in_xfer) begin
      skid_full_d = 1'b1;
      skid_imm_d  = dec_imm;
      skid_fmt_d  = dec_fmt;
      skid_ill_d  = dec_ill;
      skid_tag_d  = in_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_imm_q     <= '0;
      out_fmt_q     <= FMT_NONE;
      out_illegal_q <= 1'b0;
      out_tag_q     <= '0;
      skid_full_q   <= 1'b0;
      skid_imm_q    <= '0;
      skid_fmt_q    <= FMT_NONE;
      skid_ill_q    <= 1'b0;
      skid_tag_q    <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_imm_q     <= out_imm_d;
      out_fmt_q     <= out_fmt_d;
      out_illegal_q <= out_illegal_d;
      out_tag_q     <= out_tag_d;
      skid_full_q   <= skid_full_d;
      skid_imm_q    <= skid_imm_d;
      skid_fmt_q    <= skid_fmt_d;
      skid_ill_q    <= skid_ill_d;
      skid_tag_q    <= skid_tag_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_imm     = out_imm_q;
  assign out_fmt     = out_fmt_q;
  assign out_illegal = out_illegal_q;
  assign out_tag     = out_tag_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed and randomised checks of imm_extend_pipe. Two instances (XLEN=32
// and XLEN=64) share all inputs, so both see identical handshakes; each is
// checked against its own hand-computed expected values.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] instr;
  logic [7:0]  in_tag;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_ill32;
  logic [31:0] out_imm32;
  logic [2:0]  out_fmt32;
  logic [7:0]  out_tag32;

  logic        in_ready64, out_valid64, out_ill64;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt64;
  logic [7:0]  out_tag64;

  imm_extend_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .in_tag(in_tag), .out_valid(out_valid32),
    .out_ready(out_ready), .out_imm(out_imm32), .out_fmt(out_fmt32),
    .out_illegal(out_ill32), .out_tag(out_tag32));

  imm_extend_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .in_tag(in_tag), .out_valid(out_valid64),
    .out_ready(out_ready), .out_imm(out_imm64), .out_fmt(out_fmt64),
    .out_illegal(out_ill64), .out_tag(out_tag64));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Hand-decoded vector table
  localparam int NV = 18;
  logic [31:0] v_instr [NV];
  logic [31:0] e_imm32 [NV];
  logic [2:0]  e_fmt32 [NV];
  logic        e_ill32 [NV];
  logic [63:0] e_imm64 [NV];
  logic [2:0]  e_fmt64 [NV];
  logic        e_ill64 [NV];

  task automatic setv(input int i, input logic [31:0] ins,
                      input logic [31:0] i32, input logic [2:0] f32, input logic l32,
                      input logic [63:0] i64, input logic [2:0] f64, input logic l64);
    v_instr[i] = ins;
    e_imm32[i] = i32; e_fmt32[i] = f32; e_ill32[i] = l32;
    e_imm64[i] = i64; e_fmt64[i] = f64; e_ill64[i] = l64;
  endtask

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Output fields of both instances against table entry idx with tag t
  task automatic check_out(input string name, input int idx, input logic [7:0] t);
    chk({name, "_32"}, {out_valid32, out_imm32, out_fmt32, out_ill32, out_tag32},
        {1'b1, e_imm32[idx], e_fmt32[idx], e_ill32[idx], t});
    chk({name, "_64"}, {out_valid64, out_imm64, out_fmt64, out_ill64, out_tag64},
        {1'b1, e_imm64[idx], e_fmt64[idx], e_ill64[idx], t});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int         idx;
    logic [7:0] tag;
  } sb_t;
  sb_t sb_q[$];

  initial begin
    //        instr          imm32         f  il  imm64                  f  il
    setv( 0, 32'hFFF00093, 32'hFFFFFFFF, 1, 0, 64'hFFFFFFFFFFFFFFFF, 1, 0); // addi -1
    setv( 1, 32'hFE112E23, 32'hFFFFFFFC, 2, 0, 64'hFFFFFFFFFFFFFFFC, 2, 0); // sw -4
    setv( 2, 32'h008000EF, 32'h00000008, 5, 0, 64'h0000000000000008, 5, 0); // jal +8
    setv( 3, 32'hFE000E63, 32'hFFFFF7FC, 3, 0, 64'hFFFFFFFFFFFFF7FC, 3, 0); // beq, instr[7]=0
    setv( 4, 32'h12345037, 32'h12345000, 4, 0, 64'h0000000012345000, 4, 0); // lui
    setv( 5, 32'h4030D093, 32'h00000003, 6, 0, 64'h0000000000000003, 6, 0); // srai 3
    setv( 6, 32'h02109093, 32'h00000001, 6, 1, 64'h0000000000000021, 6, 0); // slli 33
    setv( 7, 32'h0000007F, 32'h00000000, 0, 1, 64'h0000000000000000, 0, 1); // bad opcode
    setv( 8, 32'h30529073, 32'h00000305, 7, 0, 64'h0000000000000305, 7, 0); // csrrw 0x305
    setv( 9, 32'h00208033, 32'h00000000, 0, 0, 64'h0000000000000000, 0, 0); // add
    setv(10, 32'hFFF0009B, 32'h00000000, 0, 1, 64'hFFFFFFFFFFFFFFFF, 1, 0); // addiw -1
    setv(11, 32'h0010909B, 32'h00000000, 0, 1, 64'h0000000000000001, 6, 0); // slliw 1
    setv(12, 32'h00000001, 32'h00000000, 0, 1, 64'h0000000000000000, 0, 1); // compressed
    setv(13, 32'h80000017, 32'h80000000, 4, 0, 64'hFFFFFFFF80000000, 4, 0); // auipc
    setv(14, 32'hFFC08067, 32'hFFFFFFFC, 1, 0, 64'hFFFFFFFFFFFFFFFC, 1, 0); // jalr -4
    setv(15, 32'h7FF02083, 32'h000007FF, 1, 0, 64'h00000000000007FF, 1, 0); // lw +2047
    setv(16, 32'hFFDFF0EF, 32'hFFFFFFFC, 5, 0, 64'hFFFFFFFFFFFFFFFC, 5, 0); // jal -4
    setv(17, 32'hFE000EE3, 32'hFFFFFFFC, 3, 0, 64'hFFFFFFFFFFFFFFFC, 3, 0); // beq, instr[7]=1
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instr = '0; in_tag = '0; out_ready = 1'b0;
    #2;
    chk("rst_state32", {in_ready32, out_valid32, out_imm32, out_fmt32, out_ill32, out_tag32},
        {1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 8'h0});
    chk("rst_state64", {in_ready64, out_valid64, out_imm64, out_fmt64, out_ill64, out_tag64},
        {1'b1, 1'b0, 64'h0, 3'd0, 1'b0, 8'h0});
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_idle", {in_ready32, out_valid32}, 2'b10);

    // Back-to-back stream: each result one cycle after acceptance
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      instr = v_instr[i]; in_tag = 8'(8'h10 + i);
      step();
      check_out($sformatf("dec%0d", i), i, 8'(8'h10 + i));
      chk($sformatf("dec%0d_rdy", i), in_ready32, 1'b1);
    end
    in_valid = 1'b0;
    step();
    chk("drain", {out_valid32, out_valid64}, 2'b00);

    // Backpressure: two entries fill, third waits
    out_ready = 1'b0; in_valid = 1'b1;
    instr = v_instr[0]; in_tag = 8'd1;
    step();
    check_out("bp_t1", 0, 8'd1);
    chk("bp_rdy_a", in_ready32, 1'b1);
    instr = v_instr[4]; in_tag = 8'd2;
    step();
    check_out("bp_hold_a", 0, 8'd1);
    chk("bp_rdy_b", {in_ready32, in_ready64}, 2'b00);
    instr = v_instr[1]; in_tag = 8'd3;
    step();
    check_out("bp_hold_b", 0, 8'd1);
    chk("bp_rdy_c", in_ready32, 1'b0);
    out_ready = 1'b1;
    step();
    check_out("bp_t2", 4, 8'd2);
    chk("bp_rdy_d", in_ready32, 1'b1);
    step();
    check_out("bp_t3", 1, 8'd3);
    in_valid = 1'b0;
    step();
    chk("bp_drain", out_valid32, 1'b0);

    // Asynchronous reset with both entries occupied
    out_ready = 1'b0; in_valid = 1'b1;
    instr = v_instr[2]; in_tag = 8'd4;
    step();
    instr = v_instr[3]; in_tag = 8'd5;
    step();
    chk("full_before_rst", {in_ready32, out_valid32}, 2'b01);
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst32", {in_ready32, out_valid32, out_tag32}, {1'b1, 1'b0, 8'd0});
    chk("async_rst64", {in_ready64, out_valid64, out_tag64}, {1'b1, 1'b0, 8'd0});
    step();
    rst_n = 1'b1; out_ready = 1'b1;
    step();
    chk("no_replay_a", {out_valid32, out_valid64}, 2'b00);
    step();
    chk("no_replay_b", {out_valid32, out_valid64, in_ready32}, 3'b001);

    // Random valid/ready traffic against the vector table and a FIFO scoreboard
    begin
      int n_out = 0;
      int cycles = 0;
      int cur_idx = 0;
      bit accepted = 1'b1;
      bit hold = 1'b0;
      logic [44:0] snap32;
      logic [76:0] snap64;
      in_valid = 1'b0;
      while (n_out < 10000 && cycles < 60000) begin
        if (accepted || !in_valid) begin
          in_valid = ($urandom_range(0, 3) != 0);
          cur_idx  = int'($urandom_range(0, NV - 1));
          instr    = v_instr[cur_idx];
          in_tag   = 8'($urandom_range(0, 255));
        end
        out_ready = ($urandom_range(0, 1) == 1);
        @(negedge clk);
        if (hold) begin
          chk("stall32", {out_valid32, out_imm32, out_fmt32, out_ill32, out_tag32}, snap32);
          chk("stall64", {out_valid64, out_imm64, out_fmt64, out_ill64, out_tag64}, snap64);
        end
        if (out_valid32 && out_ready) begin
          if (sb_q.size() == 0) begin
            chk("sb_extra", sb_q.size(), 1);
          end else begin
            sb_t e;
            e = sb_q.pop_front();
            check_out("rnd", e.idx, e.tag);
          end
          n_out++;
        end
        hold   = out_valid32 && !out_ready;
        snap32 = {out_valid32, out_imm32, out_fmt32, out_ill32, out_tag32};
        snap64 = {out_valid64, out_imm64, out_fmt64, out_ill64, out_tag64};
        accepted = in_valid && in_ready32;
        if (accepted) begin
          sb_t e;
          e.idx = cur_idx;
          e.tag = in_tag;
          sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        cycles++;
      end
      chk("rnd_count", n_out, 10000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
